// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch front end for a single-issue pipeline.
// Issues at most one instruction-memory request at a time, buffers a
// response that arrives during a load-use stall, discards responses that
// belong to a redirected (wrong) path, and drives the IF/ID register.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   hazard_ctrl     0 run, 1 redirect+flush, 2 stall, 3 treated as redirect
//   branch_target   redirect address (low two bits ignored)
//   im_req/im_addr  request valid / word-aligned request address
//   im_gnt          request accepted when im_req && im_gnt
//   im_rvalid/im_rdata  in-order response, one per grant
//   pc_to_ID, inst_to_ID, valid_to_ID  IF/ID register contents
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  hazard_ctrl,
  input  logic [31:0] branch_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_to_ID,
  output logic [31:0] inst_to_ID,
  output logic        valid_to_ID
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] id_pc_nxt, id_inst_nxt;
  logic        id_valid_nxt;

  logic        redirect, stall;
  logic [31:0] target, pc_inc;
  logic        deliver;
  logic [31:0] del_inst, del_pc;

  // Code 3 is reserved and behaves like a redirect, so only bit 0 matters.
  assign redirect = hazard_ctrl[0];
  assign stall    = (hazard_ctrl == 2'b10);
  assign target   = branch_target & 32'hFFFF_FFFC;
  assign pc_inc   = pc + 32'd4;

  assign im_req  = (state == S_REQ) && !rst;
  assign im_addr = pc;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop;
    buf_inst_nxt = buf_inst;
    buf_pc_nxt   = buf_pc;
    deliver      = 1'b0;
    del_inst     = buf_inst;
    del_pc       = buf_pc;

    case (state)
      S_REQ: begin
        if (im_req && im_gnt) state_nxt = S_WAIT;
        if (redirect) begin
          pc_nxt = target;
          // The just-granted request is now wrong-path; its response is dropped.
          if (im_req && im_gnt) drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (im_rvalid) begin
          state_nxt = S_REQ;
          if (drop) begin
            drop_nxt = 1'b0;
            if (redirect) pc_nxt = target;
          end else if (redirect) begin
            pc_nxt = target;
          end else if (stall) begin
            buf_inst_nxt = im_rdata;
            buf_pc_nxt   = pc;
            state_nxt    = S_HOLD;
          end else begin
            deliver  = 1'b1;
            del_inst = im_rdata;
            del_pc   = pc;
            pc_nxt   = pc_inc;
          end
        end else if (redirect) begin
          drop_nxt = 1'b1;
          pc_nxt   = target;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (!stall) begin
          deliver   = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    id_pc_nxt    = pc_to_ID;
    id_inst_nxt  = inst_to_ID;
    id_valid_nxt = valid_to_ID;
    if (redirect) begin
      id_inst_nxt  = NOP_INST;
      id_valid_nxt = 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        id_pc_nxt    = del_pc;
        id_inst_nxt  = del_inst;
        id_valid_nxt = 1'b1;
      end else begin
        id_inst_nxt  = NOP_INST;
        id_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      drop        <= 1'b0;
      buf_inst    <= '0;
      buf_pc      <= '0;
      pc_to_ID    <= '0;
      inst_to_ID  <= NOP_INST;
      valid_to_ID <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      buf_inst    <= buf_inst_nxt;
      buf_pc      <= buf_pc_nxt;
      pc_to_ID    <= id_pc_nxt;
      inst_to_ID  <= id_inst_nxt;
      valid_to_ID <= id_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. A behavioural instruction
// memory (programmable extra latency, instruction = 0xAB00_0000 ^ address)
// feeds the main instance; a second instance with RESET_PC = 0xFFFF_FFFC
// checks PC wrap-around.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [1:0]  hazard_ctrl;
  logic [31:0] branch_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] pc_to_ID;
  logic [31:0] inst_to_ID;
  logic        valid_to_ID;

  logic [1:0]  hz2;
  logic [31:0] bt2;
  logic        im_req2;
  logic [31:0] im_addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic [31:0] inst2;
  logic        valid2;

  int unsigned n_checks;
  int unsigned n_fail;

  // memory model state
  logic        pending;
  logic [31:0] pend_addr;
  int unsigned pend_delay;
  int unsigned mem_delay;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_ctrl   (hazard_ctrl),
    .branch_target (branch_target),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_gnt        (im_gnt),
    .im_rvalid     (im_rvalid),
    .im_rdata      (im_rdata),
    .pc_to_ID      (pc_to_ID),
    .inst_to_ID    (inst_to_ID),
    .valid_to_ID   (valid_to_ID)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .hazard_ctrl   (hz2),
    .branch_target (bt2),
    .im_req        (im_req2),
    .im_addr       (im_addr2),
    .im_gnt        (gnt2),
    .im_rvalid     (rvalid2),
    .im_rdata      (rdata2),
    .pc_to_ID      (pc2),
    .inst_to_ID    (inst2),
    .valid_to_ID   (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hAB00_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the handshake at negedge, advance the memory models
  // 1 time unit after posedge (DUT outputs then reflect the edge).
  task automatic tick();
    logic        g, g2, rs;
    logic [31:0] ga, ga2;
    @(negedge clk);
    g   = im_req && im_gnt;
    ga  = im_addr;
    g2  = im_req2 && gnt2;
    ga2 = im_addr2;
    rs  = rst;
    @(posedge clk);
    #1;
    im_rvalid = 1'b0;
    if (rs) begin
      pending = 1'b0;
      rvalid2 = 1'b0;
    end else begin
      if (g) begin
        pending    = 1'b1;
        pend_addr  = ga;
        pend_delay = mem_delay;
      end
      if (pending) begin
        if (pend_delay == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = inst_of(pend_addr);
          pending   = 1'b0;
        end else begin
          pend_delay--;
        end
      end
      rvalid2 = g2;
      rdata2  = inst_of(ga2);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] p, input logic [31:0] i, input logic v);
    check({tag, "_pc"}, pc_to_ID, p);
    check({tag, "_inst"}, inst_to_ID, i);
    check({tag, "_valid"}, {31'd0, valid_to_ID}, {31'd0, v});
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; hazard_ctrl = 2'd0; branch_target = '0; im_gnt = 1'b1;
    im_rvalid = 1'b0; im_rdata = '0;
    hz2 = 2'd0; bt2 = '0; gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;
    pending = 1'b0; pend_addr = '0; pend_delay = 0; mem_delay = 0;

    // reset state
    tick(); tick();
    check("rst_req", {31'd0, im_req}, 32'd0);
    check("rst_addr", im_addr, 32'h0);
    check_id("rst", 32'h0, NOP, 1'b0);

    // first cycle after release
    rst = 1'b0; #1;
    check("rel_req", {31'd0, im_req}, 32'd1);
    check("rel_addr", im_addr, 32'h0);
    check("wrap_rel_addr", im_addr2, 32'hFFFF_FFFC);

    // basic run, 1-cycle memory
    tick();                                   // grant 0x0
    check("e1_req", {31'd0, im_req}, 32'd0);
    check("e1_valid", {31'd0, valid_to_ID}, 32'd0);
    tick();                                   // deliver A
    check_id("e2", 32'h0, 32'hAB00_0000, 1'b1);
    check("e2_addr", im_addr, 32'h4);
    check("wrap_id_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_id_inst", inst2, 32'h54FF_FFFC);
    check("wrap_addr", im_addr2, 32'h0);
    tick();                                   // grant 0x4, bubble
    check_id("e3", 32'h0, NOP, 1'b0);
    tick();                                   // deliver B
    check_id("e4", 32'h4, 32'hAB00_0004, 1'b1);
    check("e4_addr", im_addr, 32'h8);
    tick();                                   // grant 0x8
    check_id("e5", 32'h4, NOP, 1'b0);

    // stall for 3 cycles with response arriving
    hazard_ctrl = 2'd2;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("hold_req", {31'd0, im_req}, 32'd0);
      check_id("hold", 32'h4, NOP, 1'b0);
    end
    hazard_ctrl = 2'd0;
    tick();                                   // deliver buffered 0x8
    check_id("e9", 32'h8, 32'hAB00_0008, 1'b1);
    check("e9_addr", im_addr, 32'hC);

    // redirect while waiting, response not yet back
    mem_delay = 2;
    tick();                                   // grant 0xC
    check("e10_valid", {31'd0, valid_to_ID}, 32'd0);
    hazard_ctrl = 2'd1; branch_target = 32'h0000_0103;
    tick();
    check("e11_req", {31'd0, im_req}, 32'd0);
    check("e11_addr", im_addr, 32'h100);
    hazard_ctrl = 2'd0;
    tick();                                   // late response now on bus
    check("e12_req", {31'd0, im_req}, 32'd0);
    tick();                                   // late response dropped
    check_id("e13", 32'h8, NOP, 1'b0);
    check("e13_req", {31'd0, im_req}, 32'd1);
    check("e13_addr", im_addr, 32'h100);
    mem_delay = 0;
    tick();
    check("e14_valid", {31'd0, valid_to_ID}, 32'd0);
    tick();
    check_id("e15", 32'h100, 32'hAB00_0100, 1'b1);

    // redirect without grant, then redirect with grant
    im_gnt = 1'b0; hazard_ctrl = 2'd1; branch_target = 32'h10;
    tick();
    check("e16_req", {31'd0, im_req}, 32'd1);
    check("e16_addr", im_addr, 32'h10);
    im_gnt = 1'b1; branch_target = 32'h200;
    tick();                                   // grant 0x10 + redirect
    check("e17_req", {31'd0, im_req}, 32'd0);
    check("e17_addr", im_addr, 32'h200);
    hazard_ctrl = 2'd0;
    tick();                                   // 0x10 response dropped
    check_id("e18", 32'h100, NOP, 1'b0);
    check("e18_addr", im_addr, 32'h200);
    tick();
    check("e19_valid", {31'd0, valid_to_ID}, 32'd0);
    tick();
    check_id("e20", 32'h200, 32'hAB00_0200, 1'b1);

    // reset while holding a buffered instruction
    tick();                                   // grant 0x204
    hazard_ctrl = 2'd2;
    tick();                                   // -> HOLD
    check("e22_req", {31'd0, im_req}, 32'd0);
    rst = 1'b1; hazard_ctrl = 2'd0;
    tick();
    check("r_req", {31'd0, im_req}, 32'd0);
    check("r_addr", im_addr, 32'h0);
    check_id("r", 32'h0, NOP, 1'b0);
    rst = 1'b0; #1;
    check("r_rel_req", {31'd0, im_req}, 32'd1);
    check("r_rel_addr", im_addr, 32'h0);
    tick();
    tick();
    check_id("r_fetch", 32'h0, 32'hAB00_0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
